// File: rtl/hazard_ctrl_if.sv
// Purpose : bundles the EX/MEM hazard inputs, the multi-cycle completion
//           inputs and the stage-control/scoreboard outputs of hazard_ctrl.
// Ports   : slave = hazard_ctrl side, master = pipeline side.
interface hazard_ctrl_if #(
  parameter int NREG = 32
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [RW-1:0]   i_ex_rs1;
  logic [RW-1:0]   i_ex_rs2;
  logic [RW-1:0]   i_ex_rd;
  logic            i_ex_rd_wren;
  logic            i_ex_mc;
  logic            i_ex_branch;
  logic [RW-1:0]   i_mem_rd;
  logic            i_mem_rd_wren;
  logic            i_mem_is_load;
  logic            i_mc_done;
  logic [RW-1:0]   i_mc_rd;
  logic            o_mc_issue;
  logic [7:0]      o_hazard;
  logic [NREG-1:0] o_busy_vec;

  modport slave (
    input  i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_rd_wren, i_ex_mc, i_ex_branch,
    input  i_mem_rd, i_mem_rd_wren, i_mem_is_load, i_mc_done, i_mc_rd,
    output o_mc_issue, o_hazard, o_busy_vec
  );

  modport master (
    output i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_rd_wren, i_ex_mc, i_ex_branch,
    output i_mem_rd, i_mem_rd_wren, i_mem_is_load, i_mc_done, i_mc_rd,
    input  o_mc_issue, o_hazard, o_busy_vec
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard unit (load-use, scoreboard, multi-cycle op) producing
//           the 8-bit {PC, IF_ID, ID_EX, EX_MEM, MEM_WB} stage-control word.
// Latency : stage control is combinational from inputs + registered state;
//           scoreboard/counters update at the clock edge.
// Backpressure: stalls hold PC/IF_ID/ID_EX and bubble EX_MEM; branch flushes
//           only when no stall is active.
// Ports   : i_clk, i_rst_n (sync active-low), bus (hazard_ctrl_if.slave).
module hazard_ctrl #(
  parameter int NREG        = 32,
  parameter int LOAD_LAT    = 1,
  parameter int MC_BLOCKING = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hazard_ctrl_if.slave  bus
);

  // ld_cnt only ever holds LOAD_LAT-1, so clog2(LOAD_LAT) bits suffice.
  localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  localparam logic [7:0] HZ_STALL = 8'b1_01_01_11_0;
  localparam logic [7:0] HZ_FLUSH = 8'b0_11_11_00_0;
  localparam logic [7:0] HZ_RUN   = 8'h00;

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   ld_cnt_q, ld_cnt_d;
  logic            mc_busy_q, mc_busy_d;
  logic            issued_q, issued_d;

  logic            ld_hit;
  logic            ld_stall;
  logic            sb_stall;
  logic            blk_stall;
  logic            any_stall;
  logic            issue;

  always_comb begin
    ld_hit    = 1'b0;
    ld_stall  = 1'b0;
    sb_stall  = 1'b0;
    blk_stall = 1'b0;
    any_stall = 1'b0;
    issue     = 1'b0;

    // New load-use detection is suppressed while the counter is running.
    ld_hit   = (ld_cnt_q == '0) && bus.i_mem_is_load && bus.i_mem_rd_wren &&
               (bus.i_mem_rd != '0) &&
               ((bus.i_mem_rd == bus.i_ex_rs1) || (bus.i_mem_rd == bus.i_ex_rs2));
    ld_stall = ld_hit || (ld_cnt_q != '0);

    // busy_q[0] is never set, so x0 operands fall out naturally.
    sb_stall = busy_q[bus.i_ex_rs1] || busy_q[bus.i_ex_rs2] ||
               (bus.i_ex_rd_wren && busy_q[bus.i_ex_rd]) ||
               (bus.i_ex_mc && mc_busy_q);

    if (MC_BLOCKING != 0) begin
      // The done cycle itself releases the pipeline.
      blk_stall = bus.i_ex_mc && !bus.i_mc_done;
      issue     = bus.i_ex_mc && !issued_q && !ld_stall && !sb_stall;
    end else begin
      issue     = bus.i_ex_mc && !ld_stall && !sb_stall && !bus.i_ex_branch;
    end

    any_stall = ld_stall || sb_stall || blk_stall;

    if (!i_rst_n) begin
      bus.o_hazard   = HZ_RUN;
      bus.o_mc_issue = 1'b0;
    end else begin
      // Stalls win over branch: branch operands in EX are not yet valid.
      if (any_stall)            bus.o_hazard = HZ_STALL;
      else if (bus.i_ex_branch) bus.o_hazard = HZ_FLUSH;
      else                      bus.o_hazard = HZ_RUN;
      bus.o_mc_issue = issue;
    end
    bus.o_busy_vec = busy_q;
  end

  always_comb begin
    busy_d    = busy_q;
    mc_busy_d = mc_busy_q;
    issued_d  = issued_q;
    ld_cnt_d  = ld_cnt_q;

    if (ld_cnt_q != '0)  ld_cnt_d = ld_cnt_q - CW'(1);
    else if (ld_hit)     ld_cnt_d = CW'(LOAD_LAT - 1);

    if (MC_BLOCKING != 0) begin
      if (bus.i_mc_done)  issued_d = 1'b0;
      else if (issue)     issued_d = 1'b1;
    end else begin
      // Clear before set so a same-rd done+issue leaves the register busy.
      if (bus.i_mc_done) begin
        busy_d[bus.i_mc_rd] = 1'b0;
        mc_busy_d           = 1'b0;
      end
      if (issue) begin
        if (bus.i_ex_rd != '0) busy_d[bus.i_ex_rd] = 1'b1;
        mc_busy_d = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy_q    <= '0;
      ld_cnt_q  <= '0;
      mc_busy_q <= 1'b0;
      issued_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      ld_cnt_q  <= ld_cnt_d;
      mc_busy_q <= mc_busy_d;
      issued_q  <= issued_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : drives three hazard_ctrl instances (LOAD_LAT=1/MC=0, LOAD_LAT=3/MC=0,
//           LOAD_LAT=1/MC=1) with shared directed vectors and checks them.
// Ports   : none (top-level bench).
module tb_hazard_ctrl;

  localparam logic [7:0] STALL = 8'hAE;  // 1_01_01_11_0
  localparam logic [7:0] FLUSH = 8'h78;  // 0_11_11_00_0
  localparam logic [7:0] RUN   = 8'h00;

  logic clk;
  logic rst_n;
  logic cmp_en;

  logic [4:0] s_rs1, s_rs2, s_rd, s_mem_rd, s_mc_rd;
  logic       s_wren, s_mc, s_br, s_mem_wren, s_mem_ld, s_done;

  logic [7:0]  dut_haz  [3];
  logic        dut_iss  [3];
  logic [31:0] dut_busy [3];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: registers pending per instance, remaining load-stall
  // cycles after the current one, outstanding mc op, blocking issue flag.
  bit pend    [3][32];
  int ld_left [3];
  bit mc_out  [3];
  bit issued  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    hazard_ctrl_if #(.NREG(32)) bus ();
    assign bus.i_ex_rs1      = s_rs1;
    assign bus.i_ex_rs2      = s_rs2;
    assign bus.i_ex_rd       = s_rd;
    assign bus.i_ex_rd_wren  = s_wren;
    assign bus.i_ex_mc       = s_mc;
    assign bus.i_ex_branch   = s_br;
    assign bus.i_mem_rd      = s_mem_rd;
    assign bus.i_mem_rd_wren = s_mem_wren;
    assign bus.i_mem_is_load = s_mem_ld;
    assign bus.i_mc_done     = s_done;
    assign bus.i_mc_rd       = s_mc_rd;
    hazard_ctrl #(
      .NREG        (32),
      .LOAD_LAT    ((k == 1) ? 3 : 1),
      .MC_BLOCKING ((k == 2) ? 1 : 0)
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
    );
    assign dut_haz[k]  = bus.o_hazard;
    assign dut_iss[k]  = bus.o_mc_issue;
    assign dut_busy[k] = bus.o_busy_vec;
  end

  function automatic int lat_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic bit blk_of(input int k);
    return (k == 2);
  endfunction

  function automatic bit load_match();
    return s_mem_ld && s_mem_wren && (s_mem_rd != 5'd0) &&
           ((s_mem_rd == s_rs1) || (s_mem_rd == s_rs2));
  endfunction

  function automatic void model_eval(input int k, output logic [7:0] h, output logic iss);
    bit ld, sb, blk;
    ld  = (ld_left[k] > 0) || load_match();
    sb  = ((s_rs1 != 5'd0) && pend[k][s_rs1]) || ((s_rs2 != 5'd0) && pend[k][s_rs2]) ||
          (s_wren && (s_rd != 5'd0) && pend[k][s_rd]) || (s_mc && mc_out[k]);
    blk = blk_of(k) && s_mc && !s_done;
    if (!rst_n) begin
      h   = RUN;
      iss = 1'b0;
    end else begin
      h = (ld || sb || blk) ? STALL : (s_br ? FLUSH : RUN);
      if (blk_of(k)) iss = s_mc && !issued[k] && !ld && !sb;
      else           iss = s_mc && !(ld || sb) && !s_br;
    end
  endfunction

  function automatic logic [31:0] model_busy(input int k);
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = pend[k][r];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: check every instance each negedge, then advance the
  // model to the state it must hold after the coming posedge.
  initial begin : cmp_proc
    logic [7:0] h;
    logic       iss;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        model_eval(k, h, iss);
        if (cmp_en) begin
          chk($sformatf("model_haz[%0d]", k),  dut_haz[k],  h);
          chk($sformatf("model_iss[%0d]", k),  dut_iss[k],  iss);
          chk($sformatf("model_busy[%0d]", k), dut_busy[k], model_busy(k));
        end
        if (!rst_n) begin
          for (int r = 0; r < 32; r++) pend[k][r] = 1'b0;
          ld_left[k] = 0;
          mc_out[k]  = 1'b0;
          issued[k]  = 1'b0;
        end else begin
          if (ld_left[k] > 0)    ld_left[k] = ld_left[k] - 1;
          else if (load_match()) ld_left[k] = lat_of(k) - 1;
          if (blk_of(k)) begin
            if (s_done)   issued[k] = 1'b0;
            else if (iss) issued[k] = 1'b1;
          end else begin
            if (s_done) begin
              pend[k][s_mc_rd] = 1'b0;
              mc_out[k]        = 1'b0;
            end
            if (iss) begin
              if (s_rd != 5'd0) pend[k][s_rd] = 1'b1;
              mc_out[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic set_nop();
    s_rs1 = '0; s_rs2 = '0; s_rd = '0; s_wren = 1'b0; s_mc = 1'b0; s_br = 1'b0;
    s_mem_rd = '0; s_mem_wren = 1'b0; s_mem_ld = 1'b0; s_done = 1'b0; s_mc_rd = '0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    s_mem_rd = rd; s_mem_wren = 1'b1; s_mem_ld = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    set_nop();
    // Reset with a live load-use hazard and an mc op on the inputs.
    set_load(5'd5); s_rs1 = 5'd5; s_mc = 1'b1;
    tick();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_haz", dut_haz[0], RUN);
    chk("rst_issue", dut_iss[0], 1'b0);
    tick();
    rst_n = 1'b1;
    set_nop();
    @(negedge clk);
    chk("post_rst_haz", dut_haz[0], RUN);
    chk("post_rst_busy", dut_busy[0], 32'h0);
    tick();

    // Load-use, MEM rd changes after the first cycle.
    set_load(5'd5); s_rs1 = 5'd5;
    @(negedge clk);
    chk("ld1_stall", dut_haz[0], STALL);
    chk("ld3_stall_c1", dut_haz[1], STALL);
    tick();
    s_mem_ld = 1'b0; s_mem_rd = 5'd9;
    @(negedge clk);
    chk("ld1_release", dut_haz[0], RUN);
    chk("ld3_stall_c2", dut_haz[1], STALL);
    tick();
    @(negedge clk);
    chk("ld3_stall_c3", dut_haz[1], STALL);
    tick();
    @(negedge clk);
    chk("ld3_release", dut_haz[1], RUN);
    tick();

    // Load-use together with a branch, then branch alone.
    set_nop();
    set_load(5'd6); s_rs2 = 5'd6; s_br = 1'b1;
    @(negedge clk);
    chk("ld_beats_branch", dut_haz[0], STALL);
    tick();
    s_mem_ld = 1'b0; s_mem_wren = 1'b0; s_mem_rd = 5'd0;
    @(negedge clk);
    chk("branch_flush", dut_haz[0], FLUSH);
    chk("ld3_beats_branch", dut_haz[1], STALL);
    tick();
    set_nop();
    tick();
    tick();

    // Non-blocking mc op rd=7.
    s_mc = 1'b1; s_rd = 5'd7; s_wren = 1'b1; s_rs1 = 5'd1; s_rs2 = 5'd2;
    @(negedge clk);
    chk("nb_issue", dut_iss[0], 1'b1);
    chk("nb_issue_run", dut_haz[0], RUN);
    chk("blk_issue_first", dut_iss[2], 1'b1);
    tick();
    set_nop(); s_rs1 = 5'd3; s_rs2 = 5'd4; s_rd = 5'd4; s_wren = 1'b1;
    @(negedge clk);
    chk("indep_run", dut_haz[0], RUN);
    chk("busy7_set", dut_busy[0], 32'h80);
    tick();
    set_nop(); s_rs1 = 5'd1; s_rs2 = 5'd7; s_rd = 5'd5; s_wren = 1'b1;
    @(negedge clk);
    chk("raw_stall", dut_haz[0], STALL);
    tick();
    tick();
    set_nop(); s_mc = 1'b1; s_rd = 5'd8; s_wren = 1'b1; s_rs1 = 5'd3;
    @(negedge clk);
    chk("struct_stall", dut_haz[0], STALL);
    chk("struct_no_issue", dut_iss[0], 1'b0);
    tick();
    set_nop(); s_rs1 = 5'd1; s_rs2 = 5'd7; s_rd = 5'd5; s_wren = 1'b1;
    s_done = 1'b1; s_mc_rd = 5'd7;
    @(negedge clk);
    chk("done_cycle_stall", dut_haz[0], STALL);
    tick();
    s_done = 1'b0; s_mc_rd = 5'd0;
    @(negedge clk);
    chk("after_done_run", dut_haz[0], RUN);
    chk("busy_cleared", dut_busy[0], 32'h0);
    tick();

    // Blocking mc op held in EX for 10 cycles, done on the 11th.
    set_nop(); s_mc = 1'b1; s_rd = 5'd9; s_wren = 1'b1; s_rs1 = 5'd1; s_rs2 = 5'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("blk_stall", dut_haz[2], STALL);
      chk("blk_issue_once", dut_iss[2], (i == 0));
      chk("blk_busy_zero", dut_busy[2], 32'h0);
      tick();
    end
    s_done = 1'b1; s_mc_rd = 5'd9;
    @(negedge clk);
    chk("blk_done_run", dut_haz[2], RUN);
    chk("blk_done_no_issue", dut_iss[2], 1'b0);
    tick();
    set_nop();
    tick();

    // mc op with rd=0 never marks a register busy.
    s_mc = 1'b1; s_rd = 5'd0; s_wren = 1'b1;
    @(negedge clk);
    chk("rd0_issue", dut_iss[0], 1'b1);
    tick();
    s_mc = 1'b0;
    @(negedge clk);
    chk("rd0_run", dut_haz[0], RUN);
    chk("rd0_busy", dut_busy[0], 32'h0);
    tick();
    set_nop(); s_done = 1'b1;
    tick();

    // Reset in the middle of a LOAD_LAT=3 stall with r7 busy.
    set_nop(); s_mc = 1'b1; s_rd = 5'd7; s_wren = 1'b1;
    tick();
    set_nop(); set_load(5'd5); s_rs1 = 5'd5;
    @(negedge clk);
    chk("mid_busy80", dut_busy[1], 32'h80);
    chk("mid_ld_stall", dut_haz[1], STALL);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_haz", dut_haz[1], RUN);
    chk("mid_rst_iss", dut_iss[1], 1'b0);
    tick();
    rst_n = 1'b1;
    set_nop();
    @(negedge clk);
    chk("mid_post_haz", dut_haz[1], RUN);
    chk("mid_post_busy", dut_busy[1], 32'h0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
